// File: rtl/m_div_controller.sv
// Sequencing FSM for the M-unit restoring divider: drives the m_registers
// R/D/Z selects, latches result selection/sign fix-up, and handles the
// RISC-V divide-by-zero and signed-overflow shortcuts.
`ifndef MUX_R_LENGTH
`define MUX_R_LENGTH 2
`endif
`ifndef MUX_D_LENGTH
`define MUX_D_LENGTH 2
`endif
`ifndef MUX_Z_LENGTH
`define MUX_Z_LENGTH 2
`endif

module m_div_controller #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic                     rs1_msb,
  input  logic                     rs2_msb,
  input  logic                     rs2_zero,
  input  logic                     rs1_min,
  input  logic                     rs2_ones,
  input  logic                     flush,
  input  logic                     sub_neg,
  input  logic                     out_ready,
  output logic [`MUX_R_LENGTH-1:0] mux_R,
  output logic [`MUX_D_LENGTH-1:0] mux_D,
  output logic [`MUX_Z_LENGTH-1:0] mux_Z,
  output logic                     ready,
  output logic                     busy,
  output logic                     out_valid,
  output logic [1:0]               res_sel,
  output logic                     res_neg
);

  // Select encodings shared with m_registers.
  localparam logic [`MUX_R_LENGTH-1:0] R_KEEP     = 2'd0;
  localparam logic [`MUX_R_LENGTH-1:0] R_A        = 2'd1;
  localparam logic [`MUX_R_LENGTH-1:0] R_A_NEG    = 2'd2;
  localparam logic [`MUX_R_LENGTH-1:0] R_SUB_KEEP = 2'd3;

  localparam logic [`MUX_D_LENGTH-1:0] D_KEEP  = 2'd0;
  localparam logic [`MUX_D_LENGTH-1:0] D_B     = 2'd1;
  localparam logic [`MUX_D_LENGTH-1:0] D_B_NEG = 2'd2;
  localparam logic [`MUX_D_LENGTH-1:0] D_SHR   = 2'd3;

  localparam logic [`MUX_Z_LENGTH-1:0] Z_KEEP    = 2'd0;
  localparam logic [`MUX_Z_LENGTH-1:0] Z_ZERO    = 2'd1;
  localparam logic [`MUX_Z_LENGTH-1:0] Z_SHL_ADD = 2'd2;

  localparam logic [1:0] SEL_Z    = 2'b00;
  localparam logic [1:0] SEL_R    = 2'b01;
  localparam logic [1:0] SEL_ONES = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       res_sel_reg, res_sel_next;
  logic             res_neg_reg, res_neg_next;

  logic signed_op, neg_a, neg_b, overflow, accept;

  // The quotient/remainder update uses sub_neg directly inside the datapath.
  logic sub_neg_unused;
  assign sub_neg_unused = sub_neg;

  assign signed_op = ~op[0];
  assign neg_a     = signed_op & rs1_msb;
  assign neg_b     = signed_op & rs2_msb;
  assign overflow  = signed_op & rs1_min & rs2_ones;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      res_sel_reg <= SEL_Z;
      res_neg_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      res_sel_reg <= res_sel_next;
      res_neg_reg <= res_neg_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    res_sel_next = res_sel_reg;
    res_neg_next = res_neg_reg;
    mux_R        = R_KEEP;
    mux_D        = D_KEEP;
    mux_Z        = Z_KEEP;
    ready        = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    accept       = 1'b0;

    case (state_reg)
      IDLE: begin
        ready = 1'b1;
      end
      ITER: begin
        busy  = 1'b1;
        mux_R = R_SUB_KEEP;
        mux_D = D_SHR;
        mux_Z = Z_SHL_ADD;
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        ready     = out_ready;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A start coinciding with the DONE handshake is accepted without an IDLE bubble.
    accept = start & ready & ~flush;
    if (accept) begin
      mux_Z = Z_ZERO;
      if (rs2_zero) begin
        mux_R        = R_A;
        res_sel_next = op[1] ? SEL_R : SEL_ONES;
        res_neg_next = 1'b0;
        state_next   = DONE;
      end else if (overflow) begin
        mux_R        = R_A;
        res_sel_next = op[1] ? SEL_Z : SEL_R;
        res_neg_next = 1'b0;
        state_next   = DONE;
      end else begin
        mux_R        = neg_a ? R_A_NEG : R_A;
        mux_D        = neg_b ? D_B_NEG : D_B;
        res_sel_next = op[1] ? SEL_R : SEL_Z;
        res_neg_next = op[1] ? neg_a : (neg_a ^ neg_b);
        cnt_next     = CNT_LAST;
        state_next   = ITER;
      end
    end

    if (flush) begin
      state_next = IDLE;
      mux_R      = R_KEEP;
      mux_D      = D_KEEP;
      mux_Z      = Z_KEEP;
    end
  end

  assign res_sel = res_sel_reg;
  assign res_neg = res_neg_reg;

`ifndef SYNTHESIS
  a_valid_not_busy: assert property (@(posedge clk) disable iff (reset) !(out_valid && busy));
  a_result_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(res_sel) && $stable(res_neg)));
`endif

endmodule

// File: tb/tb_m_div_controller.sv
// Directed self-checking bench for m_div_controller: select sequencing,
// latency, special cases, back-pressure, flush and asynchronous reset.
module tb_m_div_controller;

  localparam logic [1:0] R_KEEP = 2'd0, R_A = 2'd1, R_A_NEG = 2'd2, R_SUB_KEEP = 2'd3;
  localparam logic [1:0] D_KEEP = 2'd0, D_B = 2'd1, D_B_NEG = 2'd2, D_SHR = 2'd3;
  localparam logic [1:0] Z_KEEP = 2'd0, Z_ZERO = 2'd1, Z_SHL_ADD = 2'd2;

  logic       clk = 1'b0;
  logic       reset, start, rs1_msb, rs2_msb, rs2_zero, rs1_min, rs2_ones;
  logic       flush, sub_neg, out_ready;
  logic [1:0] op;
  logic [1:0] mux_R, mux_D, mux_Z, res_sel;
  logic       ready, busy, out_valid, res_neg;

  int checks   = 0;
  int failures = 0;

  m_div_controller dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs1_msb(rs1_msb), .rs2_msb(rs2_msb), .rs2_zero(rs2_zero),
    .rs1_min(rs1_min), .rs2_ones(rs2_ones), .flush(flush),
    .sub_neg(sub_neg), .out_ready(out_ready),
    .mux_R(mux_R), .mux_D(mux_D), .mux_Z(mux_Z),
    .ready(ready), .busy(busy), .out_valid(out_valid),
    .res_sel(res_sel), .res_neg(res_neg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; op = 2'b00; rs1_msb = 0; rs2_msb = 0; rs2_zero = 0;
    rs1_min = 0; rs2_ones = 0; flush = 0; sub_neg = 0; out_ready = 0;
  endtask

  // Steps until out_valid (bounded); counts ITER cycles with wrong selects.
  task automatic wait_done(output int n, output int bad);
    n = 0; bad = 0;
    while (!out_valid && n < 100) begin
      sub_neg = n[0];
      #1;
      if (busy !== 1'b1 || mux_R !== R_SUB_KEEP || mux_D !== D_SHR || mux_Z !== Z_SHL_ADD)
        bad++;
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    clear_inputs(); reset = 1;
    step(); step();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%0d required=1", ready); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_busy_valid actual=%0d/%0d required=0/0", busy, out_valid); end
    checks++; if (res_sel !== 2'b00 || res_neg !== 1'b0) begin failures++; $display("FAIL reset_res actual=%0d/%0d required=0/0", res_sel, res_neg); end
    checks++; if (mux_R !== R_KEEP || mux_D !== D_KEEP || mux_Z !== Z_KEEP) begin failures++; $display("FAIL reset_mux actual=%0d/%0d/%0d required=0/0/0", mux_R, mux_D, mux_Z); end
    reset = 0;
    step();
    $display("txn reset ready=%0d", ready);
  endtask

  task automatic test_divu();
    int n, bad;
    clear_inputs(); op = 2'b01; rs1_msb = 1; rs2_msb = 1; start = 1; out_ready = 1;
    #1;
    checks++; if (mux_R !== R_A || mux_D !== D_B || mux_Z !== Z_ZERO) begin failures++; $display("FAIL divu_accept_mux actual=%0d/%0d/%0d required=1/1/1", mux_R, mux_D, mux_Z); end
    step(); start = 0;
    wait_done(n, bad);
    checks++; if (n !== 32) begin failures++; $display("FAIL divu_latency actual=%0d required=32", n); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL divu_iter_selects actual=%0d required=0", bad); end
    checks++; if (res_sel !== 2'b00 || res_neg !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL divu_result actual=%0d/%0d/%0d required=0/0/0", res_sel, res_neg, busy); end
    step();
    checks++; if (out_valid !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL divu_handshake actual=%0d/%0d required=0/1", out_valid, ready); end
    $display("txn divu cycles=%0d res_sel=%0d res_neg=%0d", n, res_sel, res_neg);
  endtask

  task automatic test_signed();
    int n, bad;
    // REM -7890 % 7
    clear_inputs(); op = 2'b10; rs1_msb = 1; start = 1; out_ready = 1;
    #1;
    checks++; if (mux_R !== R_A_NEG || mux_D !== D_B) begin failures++; $display("FAIL rem_accept_mux actual=%0d/%0d required=2/1", mux_R, mux_D); end
    step(); start = 0;
    wait_done(n, bad);
    checks++; if (n !== 32 || res_sel !== 2'b01 || res_neg !== 1'b1) begin failures++; $display("FAIL rem_result actual=%0d/%0d/%0d required=32/1/1", n, res_sel, res_neg); end
    step();
    $display("txn rem cycles=%0d res_sel=%0d res_neg=%0d", n, res_sel, res_neg);
    // DIV positive / negative
    clear_inputs(); op = 2'b00; rs2_msb = 1; start = 1; out_ready = 1;
    #1;
    checks++; if (mux_R !== R_A || mux_D !== D_B_NEG) begin failures++; $display("FAIL div_negb_mux actual=%0d/%0d required=1/2", mux_R, mux_D); end
    step(); start = 0;
    wait_done(n, bad);
    checks++; if (res_sel !== 2'b00 || res_neg !== 1'b1) begin failures++; $display("FAIL div_negb_result actual=%0d/%0d required=0/1", res_sel, res_neg); end
    step();
    $display("txn div_negb cycles=%0d res_sel=%0d res_neg=%0d", n, res_sel, res_neg);
  endtask

  task automatic test_div_zero();
    clear_inputs(); op = 2'b00; rs1_msb = 1; rs2_zero = 1; rs1_min = 1; rs2_ones = 1; start = 1; out_ready = 1;
    #1;
    checks++; if (mux_R !== R_A || mux_D !== D_KEEP || mux_Z !== Z_ZERO) begin failures++; $display("FAIL divz_mux actual=%0d/%0d/%0d required=1/0/1", mux_R, mux_D, mux_Z); end
    step(); start = 0;
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0 || res_sel !== 2'b10 || res_neg !== 1'b0) begin failures++; $display("FAIL divz_result actual=%0d/%0d/%0d/%0d required=1/0/2/0", out_valid, busy, res_sel, res_neg); end
    $display("txn div_by_zero res_sel=%0d", res_sel);
    step();
    clear_inputs(); op = 2'b11; rs2_zero = 1; start = 1; out_ready = 1;
    step(); start = 0;
    checks++; if (out_valid !== 1'b1 || res_sel !== 2'b01 || res_neg !== 1'b0) begin failures++; $display("FAIL remuz_result actual=%0d/%0d/%0d required=1/1/0", out_valid, res_sel, res_neg); end
    $display("txn remu_by_zero res_sel=%0d", res_sel);
    step();
  endtask

  task automatic test_overflow();
    clear_inputs(); op = 2'b00; rs1_msb = 1; rs2_msb = 1; rs1_min = 1; rs2_ones = 1; start = 1; out_ready = 1;
    #1;
    checks++; if (mux_R !== R_A || mux_D !== D_KEEP) begin failures++; $display("FAIL ovf_mux actual=%0d/%0d required=1/0", mux_R, mux_D); end
    step(); start = 0;
    checks++; if (out_valid !== 1'b1 || res_sel !== 2'b01 || res_neg !== 1'b0) begin failures++; $display("FAIL ovf_div actual=%0d/%0d/%0d required=1/1/0", out_valid, res_sel, res_neg); end
    $display("txn div_overflow res_sel=%0d", res_sel);
    step();
    op = 2'b10; start = 1;
    step(); start = 0;
    checks++; if (out_valid !== 1'b1 || res_sel !== 2'b00 || res_neg !== 1'b0) begin failures++; $display("FAIL ovf_rem actual=%0d/%0d/%0d required=1/0/0", out_valid, res_sel, res_neg); end
    $display("txn rem_overflow res_sel=%0d", res_sel);
    step();
    // Unsigned op with the same flags is a normal division.
    op = 2'b01; start = 1;
    step(); start = 0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL divu_no_ovf actual=%0d/%0d required=1/0", busy, out_valid); end
    flush = 1; step(); flush = 0;
    $display("txn divu_minus_one busy_path");
  endtask

  task automatic test_back_to_back();
    int n, bad, hold_bad;
    clear_inputs(); op = 2'b11; start = 1;
    step(); start = 0;
    wait_done(n, bad);
    checks++; if (n !== 32 || res_sel !== 2'b01 || res_neg !== 1'b0) begin failures++; $display("FAIL bp_first actual=%0d/%0d/%0d required=32/1/0", n, res_sel, res_neg); end
    hold_bad = 0;
    start = 1; op = 2'b00; rs1_msb = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_valid !== 1'b1 || res_sel !== 2'b01 || res_neg !== 1'b0 || ready !== 1'b0 || mux_R !== R_KEEP || busy !== 1'b0)
        hold_bad++;
      step();
    end
    checks++; if (hold_bad !== 0) begin failures++; $display("FAIL bp_hold actual=%0d required=0", hold_bad); end
    out_ready = 1;
    #1;
    checks++; if (ready !== 1'b1 || mux_R !== R_A_NEG || mux_D !== D_B) begin failures++; $display("FAIL b2b_accept actual=%0d/%0d/%0d required=1/2/1", ready, mux_R, mux_D); end
    step(); start = 0;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || res_sel !== 2'b00 || res_neg !== 1'b1) begin failures++; $display("FAIL b2b_iter actual=%0d/%0d/%0d/%0d required=1/0/0/1", busy, out_valid, res_sel, res_neg); end
    $display("txn back_to_back busy=%0d res_neg=%0d", busy, res_neg);
    flush = 1; step(); flush = 0;
  endtask

  task automatic test_flush();
    int seen;
    clear_inputs(); op = 2'b00; start = 1; out_ready = 1;
    step(); start = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      step();
    end
    flush = 1; start = 1;
    #1;
    checks++; if (mux_R !== R_KEEP || mux_D !== D_KEEP || mux_Z !== Z_KEEP) begin failures++; $display("FAIL flush_mux actual=%0d/%0d/%0d required=0/0/0", mux_R, mux_D, mux_Z); end
    step(); flush = 0; start = 0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_idle actual=%0d/%0d/%0d required=1/0/0", ready, busy, out_valid); end
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step();
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL flush_no_valid actual=%0d required=0", seen); end
    $display("txn flush ready=%0d", ready);
  endtask

  task automatic test_reset_mid();
    int seen;
    clear_inputs(); op = 2'b10; rs1_msb = 1; start = 1; out_ready = 1;
    step(); start = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      step();
    end
    checks++; if (busy !== 1'b1 || res_sel !== 2'b01 || res_neg !== 1'b1) begin failures++; $display("FAIL rst_pre actual=%0d/%0d/%0d required=1/1/1", busy, res_sel, res_neg); end
    #2 reset = 1;
    #1;
    checks++; if (busy !== 1'b0 || ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_async actual=%0d/%0d/%0d required=0/1/0", busy, ready, out_valid); end
    checks++; if (res_sel !== 2'b00 || res_neg !== 1'b0 || mux_R !== R_KEEP) begin failures++; $display("FAIL rst_async_res actual=%0d/%0d/%0d required=0/0/0", res_sel, res_neg, mux_R); end
    step(); reset = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      step();
    end
    checks++; if (seen !== 0 || ready !== 1'b1) begin failures++; $display("FAIL rst_no_valid actual=%0d/%0d required=0/1", seen, ready); end
    $display("txn reset_mid ready=%0d", ready);
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
